// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS multiply/divide sequencer.
package mips_pkg;

  localparam int DATA_WIDTH     = 32;
  localparam int MULDIV_LATENCY = DATA_WIDTH + 2;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } muldiv_state_e;

  // Bit 0 of the opcode marks the unsigned variants.
  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  // Bit 1 of the opcode selects the divide path.
  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/mips_muldiv_step.sv
// One iteration of unsigned shift-add multiply or restoring shift-subtract divide
// on the {acc,q} register pair.
module mips_muldiv_step #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  mode_div,
  input  logic [DATA_WIDTH-1:0] acc_in,
  input  logic [DATA_WIDTH-1:0] q_in,
  input  logic [DATA_WIDTH-1:0] operand,
  output logic [DATA_WIDTH-1:0] acc_out,
  output logic [DATA_WIDTH-1:0] q_out
);

  logic [DATA_WIDTH:0] sum;
  logic [DATA_WIDTH:0] rem_sh;
  logic [DATA_WIDTH:0] diff;

  // Multiply: add multiplicand when the multiplier LSB is set, then shift the
  // pair right. Divide: shift left, keep the trial subtraction if it did not borrow.
  always_comb begin
    acc_out = acc_in;
    q_out   = q_in;
    sum     = {1'b0, acc_in} + (q_in[0] ? {1'b0, operand} : '0);
    rem_sh  = {acc_in, q_in[DATA_WIDTH-1]};
    diff    = rem_sh - {1'b0, operand};
    if (mode_div) begin
      if (!diff[DATA_WIDTH]) begin
        acc_out = diff[DATA_WIDTH-1:0];
        q_out   = {q_in[DATA_WIDTH-2:0], 1'b1};
      end else begin
        acc_out = rem_sh[DATA_WIDTH-1:0];
        q_out   = {q_in[DATA_WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_out = sum[DATA_WIDTH:1];
      q_out   = {sum[0], q_in[DATA_WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mips_muldiv_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer driving the HI/LO writes.
//
// state | meaning
// IDLE  | waiting for start; outputs hold last result
// RUN   | one multiply/divide iteration per clock, cnt counts down to 0
// FIX   | sign correction of the magnitude result, loaded into hi/lo
// DONE  | done/hi_write/lo_write pulse for one cycle
module mips_muldiv_seq #(
  parameter int DATA_WIDTH = mips_pkg::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] rs_val,
  input  logic [DATA_WIDTH-1:0] rt_val,
  input  logic                  flush,
  output logic                  busy,
  output logic                  done,
  output logic                  hi_write,
  output logic                  lo_write,
  output logic [DATA_WIDTH-1:0] hi_out,
  output logic [DATA_WIDTH-1:0] lo_out,
  output logic                  div_by_zero
);
  import mips_pkg::*;

  localparam int                CNT_W    = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  muldiv_state_e state_q, state_d;

  logic [CNT_W-1:0]        cnt_q;
  logic                    is_div_q;
  logic                    neg_rs_q;
  logic                    neg_rt_q;
  logic                    rt_zero_q;
  logic                    dbz_q;
  logic [DATA_WIDTH-1:0]   rs_raw_q;
  logic [DATA_WIDTH-1:0]   opnd_q;
  logic [DATA_WIDTH-1:0]   acc_q;
  logic [DATA_WIDTH-1:0]   q_q;
  logic [DATA_WIDTH-1:0]   hi_q;
  logic [DATA_WIDTH-1:0]   lo_q;

  logic                    sgn;
  logic                    accept;
  logic [DATA_WIDTH-1:0]   rs_abs;
  logic [DATA_WIDTH-1:0]   rt_abs;
  logic [DATA_WIDTH-1:0]   acc_step;
  logic [DATA_WIDTH-1:0]   q_step;
  logic [2*DATA_WIDTH-1:0] prod_fix;
  logic [DATA_WIDTH-1:0]   quo_fix;
  logic [DATA_WIDTH-1:0]   rem_fix;
  logic [DATA_WIDTH-1:0]   hi_fix;
  logic [DATA_WIDTH-1:0]   lo_fix;

  assign sgn    = op_is_signed(op);
  assign accept = (state_q == ST_IDLE) && start && !flush;
  assign rs_abs = (sgn && rs_val[DATA_WIDTH-1]) ? -rs_val : rs_val;
  assign rt_abs = (sgn && rt_val[DATA_WIDTH-1]) ? -rt_val : rt_val;

  mips_muldiv_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
    .mode_div (is_div_q),
    .acc_in   (acc_q),
    .q_in     (q_q),
    .operand  (opnd_q),
    .acc_out  (acc_step),
    .q_out    (q_step)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; flush from any busy state returns straight to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_RUN;
      ST_RUN: begin
        if (flush)              state_d = ST_IDLE;
        else if (cnt_q == '0)   state_d = ST_FIX;
      end
      ST_FIX:  state_d = flush ? ST_IDLE : ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand capture on launch and one iteration per RUN cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_rs_q  <= 1'b0;
      neg_rt_q  <= 1'b0;
      rt_zero_q <= 1'b0;
      rs_raw_q  <= '0;
      opnd_q    <= '0;
      acc_q     <= '0;
      q_q       <= '0;
    end else if (accept) begin
      cnt_q     <= CNT_LAST;
      is_div_q  <= op_is_div(op);
      neg_rs_q  <= sgn & rs_val[DATA_WIDTH-1];
      neg_rt_q  <= sgn & rt_val[DATA_WIDTH-1];
      rt_zero_q <= (rt_val == '0);
      rs_raw_q  <= rs_val;
      opnd_q    <= op_is_div(op) ? rt_abs : rs_abs;
      acc_q     <= '0;
      q_q       <= op_is_div(op) ? rs_abs : rt_abs;
    end else if (state_q == ST_RUN && !flush) begin
      cnt_q <= cnt_q - 1'b1;
      acc_q <= acc_step;
      q_q   <= q_step;
    end
  end

  // Sign correction; divide-by-zero returns the raw dividend and all-ones quotient.
  always_comb begin
    prod_fix = {acc_q, q_q};
    if (neg_rs_q ^ neg_rt_q) prod_fix = -{acc_q, q_q};
    quo_fix = (neg_rs_q ^ neg_rt_q) ? -q_q : q_q;
    rem_fix = neg_rs_q ? -acc_q : acc_q;
    hi_fix  = prod_fix[2*DATA_WIDTH-1:DATA_WIDTH];
    lo_fix  = prod_fix[DATA_WIDTH-1:0];
    if (is_div_q) begin
      if (rt_zero_q) begin
        hi_fix = rs_raw_q;
        lo_fix = '1;
      end else begin
        hi_fix = rem_fix;
        lo_fix = quo_fix;
      end
    end
  end

  // Result registers load only on the FIX->DONE transition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q  <= '0;
      lo_q  <= '0;
      dbz_q <= 1'b0;
    end else if (state_q == ST_FIX && !flush) begin
      hi_q  <= hi_fix;
      lo_q  <= lo_fix;
      dbz_q <= is_div_q & rt_zero_q;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);
  assign hi_write    = done;
  assign lo_write    = done;
  assign hi_out      = hi_q;
  assign lo_out      = lo_q;
  assign div_by_zero = done & dbz_q;

endmodule
